mskkey_ctrl: RTL and testbench
==============================

// Module: MSKkey_ctrl
// PURPOSE
//  Sequencer for the masked key holder. Accepts key-share chunks from the host and forwards them.
//  Schedules share refreshes: handshakes fresh randomness from the PRNG, then pulses pre_pre_refresh.
//  Tracks the holder pipeline and tells the Clyde core when the key sharing is valid, honouring a core lock.
// PARAMETERS
//  d            2     number of shares
//  Nbits        128   key width per share
//  FEED_SIZE    32    chunk width; d*Nbits % FEED_SIZE==0, NCHUNK=d*Nbits/FEED_SIZE (8 by default)
//  RFRSH_PERIOD 1024  cycles between automatic refreshes (only with MSK_KEY_PERIODIC_RFRSH_EN)
// PORTS
//  clk             in   1          clock
//  rst             in   1          asynchronous reset, active low
//  key_in          in   FEED_SIZE  key-share chunk from host
//  key_in_valid    in   1          chunk valid
//  key_in_ready    out  1          chunk accepted when valid&ready
//  refresh_req     in   1          core/host requests a refresh (level or pulse, latched)
//  key_lock        in   1          core is using the sharing; no refresh/load may start
//  rnd_req         out  1          randomness requested / held by the holder
//  rnd_valid       in   1          PRNG: (d-1)*Nbits fresh bits valid on the holder rnd bus
//  rnd_used        out  1          1-cycle pulse: holder sampled rnd, PRNG may advance
//  data_in         out  FEED_SIZE  to holder
//  data_in_valid   out  1          to holder
//  pre_pre_refresh out  1          to holder
//  key_valid       out  1          holder sharing valid and stable
//  busy            out  1          state != READY and != EMPTY
// BEHAVIOUR
//  Reset: all outputs 0, state EMPTY, cnt=0, pending=0, takes effect immediately (mid-load/refresh aborts).
//  All outputs registered except key_in_ready = (state in EMPTY/READY/LOAD) & !key_lock_guard, where
//  key_lock_guard = key_lock & (state==READY).
//  data_in/data_in_valid = key_in/(key_in_valid&key_in_ready) delayed one cycle.
//  States:
//   EMPTY : no key. Handshake -> LOAD, cnt=1.
//   LOAD  : each handshake cnt++. Handshake with cnt==NCHUNK-1 -> SETTLE, cnt=0. Idle cycles are allowed.
//   SETTLE: 2 cycles (holder latency); then pending? RNDW : READY. key_valid rises the cycle READY entered.
//   READY : key_valid=1. Handshake (not locked) -> LOAD, cnt=1, key_valid=0 next cycle.
//           else (refresh_req|pending)&!key_lock -> RNDW, key_valid=0 next cycle.
//   RNDW  : rnd_req=1; on rnd_valid -> RFR, pre_pre_refresh=1 next cycle (one cycle only).
//   RFR   : 3-cycle countdown from the pre_pre_refresh cycle t. rnd_req held through t+1 (holder samples rnd),
//           rnd_used pulses at t+1 and rnd_req drops at t+2. Holder key updated end of t+2. -> READY;
//           key_valid=1 at t+3. pending cleared on entry to RNDW.
//  refresh_req seen in any state other than READY sets pending; served as soon as READY and unlocked.
//  Simultaneous load handshake and refresh in READY: load wins, pending set; refresh follows SETTLE.
//  Completed load always leads to a refresh if pending; a refresh never starts while key_lock=1.
//  key_lock asserted during RNDW/RFR is ignored (key_valid already 0); the core must wait on key_valid.
//  rnd_valid outside RNDW is ignored; PRNG holds rnd stable while rnd_req=1.
//  cnt width = $clog2(NCHUNK); no wrap beyond NCHUNK-1.
// CONFIGURATION
//  MSK_KEY_PERIODIC_RFRSH_EN defined: 32-bit timer counts cycles in READY and sets pending at RFRSH_PERIOD.
//    The timer then restarts; it resets to 0 on every refresh or load.
//  Undefined: no timer; refreshes only from refresh_req. Timer logic absent.
// TESTING
//  Reset, 8 chunks back-to-back 0x0..0x7 -> data_in_valid 8 cycles; data_in matches 1 cycle late; key_valid 2 cycles after last.
//  READY, refresh_req pulse, rnd_valid 3 cycles later -> pre_pre_refresh 1 cycle; rnd_used next; key_valid back 3 cycles after ppr.
//  READY, key_lock=1 plus refresh_req -> no rnd_req until key_lock falls; then RNDW within 1 cycle.
//  refresh_req during chunk 4 of a load -> after SETTLE enters RNDW directly; key_valid stays 0 until refresh done.
//  rst low during RFR (t+1) -> all outputs 0 immediately; EMPTY; key_in_ready=1 after release.
//  Periodic macro, RFRSH_PERIOD=16, READY idle -> rnd_req rises 16 cycles after READY entry, repeats every cycle of READY+16.

Source files
------------

// File: rtl/mskkey_ctrl.sv
// mskkey_ctrl: sequencer for the masked key holder (load, settle, refresh).
// Ports: clk, rst (async active-low); host key_in/key_in_valid/key_in_ready;
//   refresh_req, key_lock from core; rnd_req/rnd_valid/rnd_used PRNG handshake;
//   data_in/data_in_valid/pre_pre_refresh to holder; key_valid, busy status.
// Build option: define MSK_KEY_PERIODIC_RFRSH_EN for the periodic refresh timer.
module mskkey_ctrl #(
    parameter int d            = 2,
    parameter int Nbits        = 128,
    parameter int FEED_SIZE    = 32,
    parameter int RFRSH_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FEED_SIZE-1:0] key_in,
    input  logic                 key_in_valid,
    output logic                 key_in_ready,
    input  logic                 refresh_req,
    input  logic                 key_lock,
    output logic                 rnd_req,
    input  logic                 rnd_valid,
    output logic                 rnd_used,
    output logic [FEED_SIZE-1:0] data_in,
    output logic                 data_in_valid,
    output logic                 pre_pre_refresh,
    output logic                 key_valid,
    output logic                 busy
);

    localparam int NCHUNK = d * Nbits / FEED_SIZE;
    // RFR phase counting needs values up to 2 even for tiny NCHUNK.
    localparam int CNT_W  = ($clog2(NCHUNK) < 2) ? 2 : $clog2(NCHUNK);

    if (((d * Nbits) % FEED_SIZE) != 0 || RFRSH_PERIOD < 1) begin : g_bad_cfg
        $error("mskkey_ctrl: invalid parameter set");
    end

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] READY  = 3'd3;
    localparam logic [2:0] RNDW   = 3'd4;
    localparam logic [2:0] RFR    = 3'd5;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

    logic [2:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             pending, pending_d;
    logic             key_valid_d;
    logic             rnd_req_d;
    logic             rnd_used_d;
    logic             ppr_d;
    logic             busy_d;
    logic             hs;
    logic             lock_guard;
    logic             tmr_hit;

    assign lock_guard   = key_lock & (state == READY);
    // Held low during reset so every output reads 0 while rst is asserted.
    assign key_in_ready = rst
                        & ((state == EMPTY) | (state == READY) | (state == LOAD))
                        & ~lock_guard;
    assign hs           = key_in_valid & key_in_ready;

`ifdef MSK_KEY_PERIODIC_RFRSH_EN
    localparam logic [31:0] TMR_LAST = 32'(RFRSH_PERIOD - 1);

    logic [31:0] tmr;

    // Hit on the last READY cycle of the period so rnd_req rises exactly
    // RFRSH_PERIOD cycles after READY entry.
    assign tmr_hit = (state == READY) && (tmr == TMR_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (state != READY || tmr_hit) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + 32'd1;
        end
    end
`else
    assign tmr_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pending_d   = pending | refresh_req | tmr_hit;
        key_valid_d = key_valid;
        rnd_req_d   = rnd_req;
        rnd_used_d  = 1'b0;
        ppr_d       = 1'b0;
        unique case (state)
            EMPTY: begin
                if (hs) begin
                    state_d = LOAD;
                    cnt_d   = ONE;
                end
            end
            LOAD: begin
                if (hs) begin
                    if (cnt == LAST) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt == ONE) begin
                    cnt_d = '0;
                    if (pending_d && !key_lock) begin
                        state_d   = RNDW;
                        rnd_req_d = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d     = READY;
                        key_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            READY: begin
                // A load beats a refresh; the refresh stays pending.
                if (hs) begin
                    state_d     = LOAD;
                    cnt_d       = ONE;
                    key_valid_d = 1'b0;
                end else if (pending_d && !key_lock) begin
                    state_d     = RNDW;
                    key_valid_d = 1'b0;
                    rnd_req_d   = 1'b1;
                    pending_d   = 1'b0;
                end
            end
            RNDW: begin
                if (rnd_valid) begin
                    state_d = RFR;
                    cnt_d   = '0;
                    ppr_d   = 1'b1;
                end
            end
            RFR: begin
                // cnt 0: ppr cycle, 1: holder samples rnd, 2: holder updates.
                if (cnt == '0) begin
                    rnd_used_d = 1'b1;
                    cnt_d      = ONE;
                end else if (cnt == ONE) begin
                    rnd_req_d = 1'b0;
                    cnt_d     = TWO;
                end else begin
                    state_d     = READY;
                    key_valid_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d     = EMPTY;
                cnt_d       = '0;
                key_valid_d = 1'b0;
                rnd_req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != READY) && (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= EMPTY;
            cnt             <= '0;
            pending         <= 1'b0;
            key_valid       <= 1'b0;
            rnd_req         <= 1'b0;
            rnd_used        <= 1'b0;
            pre_pre_refresh <= 1'b0;
            busy            <= 1'b0;
            data_in         <= '0;
            data_in_valid   <= 1'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            pending         <= pending_d;
            key_valid       <= key_valid_d;
            rnd_req         <= rnd_req_d;
            rnd_used        <= rnd_used_d;
            pre_pre_refresh <= ppr_d;
            busy            <= busy_d;
            data_in         <= key_in;
            data_in_valid   <= hs;
        end
    end

endmodule

// File: tb/tb_mskkey_ctrl.sv
// tb_mskkey_ctrl: directed self-checking bench for mskkey_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mskkey_ctrl;

`ifdef MSK_KEY_PERIODIC_RFRSH_EN
    localparam int PER = 16;
`else
    localparam int PER = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] key_in = '0;
    logic        key_in_valid = 1'b0;
    logic        key_in_ready;
    logic        refresh_req = 1'b0;
    logic        key_lock = 1'b0;
    logic        rnd_req;
    logic        rnd_valid = 1'b0;
    logic        rnd_used;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        pre_pre_refresh;
    logic        key_valid;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mskkey_ctrl #(
        .d(2), .Nbits(128), .FEED_SIZE(32), .RFRSH_PERIOD(PER)
    ) dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_in_valid(key_in_valid),
        .key_in_ready(key_in_ready),
        .refresh_req(refresh_req), .key_lock(key_lock),
        .rnd_req(rnd_req), .rnd_valid(rnd_valid), .rnd_used(rnd_used),
        .data_in(data_in), .data_in_valid(data_in_valid),
        .pre_pre_refresh(pre_pre_refresh),
        .key_valid(key_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick; tick;
        n_chk++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_kir: got %b required 0", key_in_ready); end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_kv: got %b required 0", key_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_chk++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL rst_rnd_req: got %b required 0", rnd_req); end
        n_chk++; if (rnd_used !== 1'b0) begin n_fail++; $display("FAIL rst_rnd_used: got %b required 0", rnd_used); end
        n_chk++; if (pre_pre_refresh !== 1'b0) begin n_fail++; $display("FAIL rst_ppr: got %b required 0", pre_pre_refresh); end
        n_chk++; if (data_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_div: got %b required 0", data_in_valid); end
        n_chk++; if (data_in !== 32'h0) begin n_fail++; $display("FAIL rst_di: got %h required 0", data_in); end
        rst = 1'b1;
        #1;
        n_chk++; if (key_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_kir: got %b required 1", key_in_ready); end
        tick;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_busy: got %b required 0", busy); end
    endtask

    task automatic test_load;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i > 0) begin
                n_chk++; if (data_in_valid !== 1'b1 || data_in !== 32'(i - 1)) begin n_fail++; $display("FAIL load_data%0d: got %b/%h required 1/%h", i - 1, data_in_valid, data_in, i - 1); end
            end
            key_in = 32'(i);
            key_in_valid = 1'b1;
        end
        tick;
        key_in_valid = 1'b0;
        n_chk++; if (data_in_valid !== 1'b1 || data_in !== 32'h7) begin n_fail++; $display("FAIL load_data7: got %b/%h required 1/7", data_in_valid, data_in); end
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL settle_kv0: got %b required 0", key_valid); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL settle_busy: got %b required 1", busy); end
        n_chk++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL settle_kir: got %b required 0", key_in_ready); end
        tick;
        n_chk++; if (key_valid !== 1'b0 || data_in_valid !== 1'b0) begin n_fail++; $display("FAIL settle_kv1: got %b/%b required 0/0", key_valid, data_in_valid); end
        tick;
        n_chk++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ready_kv: got %b required 1", key_valid); end
        n_chk++; if (busy !== 1'b0 || key_in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_busy_kir: got %b/%b required 0/1", busy, key_in_ready); end
    endtask

    task automatic test_refresh;
        refresh_req = 1'b1;
        tick;
        refresh_req = 1'b0;
        n_chk++; if (rnd_req !== 1'b1 || key_valid !== 1'b0) begin n_fail++; $display("FAIL rf_rndw: got req %b kv %b required 1/0", rnd_req, key_valid); end
        n_chk++; if (busy !== 1'b1 || key_in_ready !== 1'b0) begin n_fail++; $display("FAIL rf_busy_kir: got %b/%b required 1/0", busy, key_in_ready); end
        tick; tick;
        n_chk++; if (rnd_req !== 1'b1 || pre_pre_refresh !== 1'b0) begin n_fail++; $display("FAIL rf_wait: got req %b ppr %b required 1/0", rnd_req, pre_pre_refresh); end
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        n_chk++; if (pre_pre_refresh !== 1'b1 || rnd_used !== 1'b0 || rnd_req !== 1'b1) begin n_fail++; $display("FAIL rf_t: got ppr %b used %b req %b required 1/0/1", pre_pre_refresh, rnd_used, rnd_req); end
        tick;
        n_chk++; if (pre_pre_refresh !== 1'b0 || rnd_used !== 1'b1 || rnd_req !== 1'b1) begin n_fail++; $display("FAIL rf_t1: got ppr %b used %b req %b required 0/1/1", pre_pre_refresh, rnd_used, rnd_req); end
        tick;
        n_chk++; if (rnd_used !== 1'b0 || rnd_req !== 1'b0 || key_valid !== 1'b0) begin n_fail++; $display("FAIL rf_t2: got used %b req %b kv %b required 0/0/0", rnd_used, rnd_req, key_valid); end
        tick;
        n_chk++; if (key_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rf_t3: got kv %b busy %b required 1/0", key_valid, busy); end
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        n_chk++; if (pre_pre_refresh !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_ignored: got ppr %b busy %b required 0/0", pre_pre_refresh, busy); end
    endtask

    task automatic test_lock;
        key_lock = 1'b1;
        refresh_req = 1'b1;
        key_in = 32'hAA;
        key_in_valid = 1'b1;
        #1;
        n_chk++; if (key_in_ready !== 1'b0) begin n_fail++; $display("FAIL lock_kir: got %b required 0", key_in_ready); end
        tick;
        refresh_req = 1'b0;
        key_in_valid = 1'b0;
        n_chk++; if (rnd_req !== 1'b0 || key_valid !== 1'b1 || data_in_valid !== 1'b0) begin n_fail++; $display("FAIL lock_hold: got req %b kv %b div %b required 0/1/0", rnd_req, key_valid, data_in_valid); end
        tick; tick;
        n_chk++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL lock_hold2: got %b required 0", rnd_req); end
        key_lock = 1'b0;
        tick;
        n_chk++; if (rnd_req !== 1'b1 || key_valid !== 1'b0) begin n_fail++; $display("FAIL unlock_rndw: got req %b kv %b required 1/0", rnd_req, key_valid); end
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        n_chk++; if (pre_pre_refresh !== 1'b1) begin n_fail++; $display("FAIL unlock_ppr: got %b required 1", pre_pre_refresh); end
        tick; tick; tick;
        n_chk++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL unlock_kv: got %b required 1", key_valid); end
    endtask

    task automatic test_load_refresh;
        for (int i = 0; i < 8; i++) begin
            tick;
            key_in = 32'h10 + 32'(i);
            key_in_valid = 1'b1;
            refresh_req = (i == 4);
        end
        tick;
        key_in_valid = 1'b0;
        n_chk++; if (data_in !== 32'h17 || key_valid !== 1'b0 || rnd_req !== 1'b0) begin n_fail++; $display("FAIL lr_settle: got di %h kv %b req %b required 17/0/0", data_in, key_valid, rnd_req); end
        tick; tick;
        n_chk++; if (rnd_req !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL lr_rndw: got req %b kv %b busy %b required 1/0/1", rnd_req, key_valid, busy); end
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        n_chk++; if (pre_pre_refresh !== 1'b1) begin n_fail++; $display("FAIL lr_ppr: got %b required 1", pre_pre_refresh); end
        tick; tick;
        n_chk++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL lr_t2_kv: got %b required 0", key_valid); end
        tick;
        n_chk++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL lr_t3_kv: got %b required 1", key_valid); end
    endtask

    task automatic test_load_wins;
        key_in = 32'h20;
        key_in_valid = 1'b1;
        refresh_req = 1'b1;
        tick;
        refresh_req = 1'b0;
        n_chk++; if (data_in_valid !== 1'b1 || busy !== 1'b1 || rnd_req !== 1'b0 || key_valid !== 1'b0) begin n_fail++; $display("FAIL lw_load: got div %b busy %b req %b kv %b required 1/1/0/0", data_in_valid, busy, rnd_req, key_valid); end
        for (int i = 1; i < 8; i++) begin
            key_in = 32'h20 + 32'(i);
            tick;
        end
        key_in_valid = 1'b0;
        tick;
        n_chk++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL lw_settle: got %b required 0", rnd_req); end
        tick;
        n_chk++; if (rnd_req !== 1'b1 || key_valid !== 1'b0) begin n_fail++; $display("FAIL lw_rndw: got req %b kv %b required 1/0", rnd_req, key_valid); end
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        tick; tick; tick;
        n_chk++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL lw_kv: got %b required 1", key_valid); end
    endtask

`ifdef MSK_KEY_PERIODIC_RFRSH_EN
    task automatic test_periodic;
        for (int i = 0; i < 15; i++) tick;
        n_chk++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL per_early: got %b required 0", rnd_req); end
        tick;
        n_chk++; if (rnd_req !== 1'b1) begin n_fail++; $display("FAIL per_rise: got %b required 1", rnd_req); end
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        tick; tick; tick;
        n_chk++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL per_kv: got %b required 1", key_valid); end
    endtask
`else
    task automatic test_periodic;
        for (int i = 0; i < 20; i++) tick;
        n_chk++; if (rnd_req !== 1'b0 || key_valid !== 1'b1) begin n_fail++; $display("FAIL no_timer: got req %b kv %b required 0/1", rnd_req, key_valid); end
    endtask
`endif

    task automatic test_reset_mid;
        refresh_req = 1'b1;
        tick;
        refresh_req = 1'b0;
        rnd_valid = 1'b1;
        tick;
        rnd_valid = 1'b0;
        n_chk++; if (pre_pre_refresh !== 1'b1) begin n_fail++; $display("FAIL rm_ppr: got %b required 1", pre_pre_refresh); end
        tick;
        n_chk++; if (rnd_used !== 1'b1) begin n_fail++; $display("FAIL rm_used: got %b required 1", rnd_used); end
        rst = 1'b0;
        #1;
        n_chk++; if (rnd_req !== 1'b0 || rnd_used !== 1'b0 || pre_pre_refresh !== 1'b0) begin n_fail++; $display("FAIL rm_rnd: got req %b used %b ppr %b required 0/0/0", rnd_req, rnd_used, pre_pre_refresh); end
        n_chk++; if (key_valid !== 1'b0 || busy !== 1'b0 || key_in_ready !== 1'b0 || data_in_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out: got kv %b busy %b kir %b div %b required 0/0/0/0", key_valid, busy, key_in_ready, data_in_valid); end
        tick;
        rst = 1'b1;
        #1;
        n_chk++; if (key_in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_kir: got %b required 1", key_in_ready); end
        tick;
        n_chk++; if (busy !== 1'b0 || key_valid !== 1'b0 || rnd_req !== 1'b0) begin n_fail++; $display("FAIL rm_empty: got busy %b kv %b req %b required 0/0/0", busy, key_valid, rnd_req); end
        key_in = 32'h5;
        key_in_valid = 1'b1;
        tick;
        key_in_valid = 1'b0;
        n_chk++; if (busy !== 1'b1 || data_in !== 32'h5 || data_in_valid !== 1'b1) begin n_fail++; $display("FAIL rm_load: got busy %b di %h div %b required 1/5/1", busy, data_in, data_in_valid); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_refresh;
        test_lock;
        test_load_refresh;
        test_load_wins;
        test_periodic;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
